// File: rtl/mdu_seq_if.sv
// Start/busy/done handshake and HI/LO result bus between pipeline control and mdu_seq.
// MDU_HILO_WRITE_EN adds the direct HI/LO write port used by MTHI/MTLO.
interface mdu_seq_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
`ifdef MDU_HILO_WRITE_EN
    logic [1:0]   hilo_we;
    logic [N-1:0] hilo_wdata;
`endif

    modport master (
        output start, op, a, b, flush,
`ifdef MDU_HILO_WRITE_EN
        output hilo_we, hilo_wdata,
`endif
        input  busy, done, hi, lo, dbz
    );

    modport slave (
        input  start, op, a, b, flush,
`ifdef MDU_HILO_WRITE_EN
        input  hilo_we, hilo_wdata,
`endif
        output busy, done, hi, lo, dbz
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer holding HI/LO, one shared add/subtract path.
// Optional MDU_HILO_WRITE_EN: direct HI/LO writes from IDLE (MTHI/MTLO).
module mdu_seq #(
    parameter int unsigned N = 32
) (
    input logic      clk,
    input logic      rst_n,
    mdu_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned W2 = 2 * N;

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t        state_q, state_nx;
    logic [1:0]    op_q;
    logic [N-1:0]  a_q, b_q;
    logic [W2-1:0] acc;
    logic [N-1:0]  rem;
    logic [CW-1:0] cnt;
    logic          neg_q, neg_r, dbz_pend;
    logic          busy_q, done_q, dbz_q;
    logic [N-1:0]  hi_q, lo_q;

    logic          load_c, prep_c, iter_c, fix_c;
    logic          is_div, a_neg, b_neg;
    logic [N-1:0]  abs_a, abs_b;
    logic [N:0]    shifted, add_x, add_y;
    logic [N+1:0]  sum;
    logic [W2-1:0] prod;
    logic [N-1:0]  quo, remf;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.dbz  = dbz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        if (bus.flush) begin
            state_nx = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_nx = PREP;
                PREP:    state_nx = ITER;
                ITER:    if (cnt == CW'(N - 1)) state_nx = FIX;
                FIX:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        load_c = 1'b0;
        prep_c = 1'b0;
        iter_c = 1'b0;
        fix_c  = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                IDLE:    load_c = bus.start;
                PREP:    prep_c = 1'b1;
                ITER:    iter_c = 1'b1;
                FIX:     fix_c  = 1'b1;
                default: ;
            endcase
        end
    end

    // Operand magnitudes for signed ops; op[0] selects signed, op[1] selects divide
    always_comb begin
        is_div = op_q[1];
        a_neg  = op_q[0] & a_q[N-1];
        b_neg  = op_q[0] & b_q[N-1];
        abs_a  = a_neg ? N'(N'(0) - a_q) : a_q;
        abs_b  = b_neg ? N'(N'(0) - b_q) : b_q;
    end

    // Single adder: high half + multiplicand, or shifted remainder - divisor
    always_comb begin
        shifted = {rem, acc[N-1]};
        add_x   = is_div ? shifted : {1'b0, acc[W2-1:N]};
        add_y   = {1'b0, b_q};
        sum     = {1'b0, add_x} + ({1'b0, add_y} ^ {(N + 2){is_div}}) + (N + 2)'(is_div);
    end

    always_comb begin
        prod = neg_q ? W2'(W2'(0) - acc) : acc;
        quo  = neg_q ? N'(N'(0) - acc[N-1:0]) : acc[N-1:0];
        remf = neg_r ? N'(N'(0) - rem) : rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz_pend <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= fix_c;
            if (load_c) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
            if (prep_c) begin
                acc      <= {N'(0), abs_a};
                b_q      <= abs_b;
                rem      <= '0;
                cnt      <= '0;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                dbz_pend <= is_div & (b_q == N'(0));
            end
            if (iter_c) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    rem          <= sum[N+1] ? shifted[N-1:0] : sum[N-1:0];
                    acc[N-1:0]   <= {acc[N-2:0], ~sum[N+1]};
                end else if (acc[0]) begin
                    acc <= {sum[N:0], acc[N-1:1]};
                end else begin
                    acc <= {1'b0, acc[W2-1:1]};
                end
            end
            if (fix_c) begin
                if (is_div && dbz_pend) begin
                    hi_q  <= a_q;
                    lo_q  <= '1;
                    dbz_q <= 1'b1;
                end else if (is_div) begin
                    hi_q  <= remf;
                    lo_q  <= quo;
                    dbz_q <= 1'b0;
                end else begin
                    hi_q  <= prod[W2-1:N];
                    lo_q  <= prod[N-1:0];
                    dbz_q <= 1'b0;
                end
            end
`ifdef MDU_HILO_WRITE_EN
            // MTHI/MTLO only from an idle unit with no competing start
            if (state_q == IDLE && !bus.start && !bus.flush) begin
                if (bus.hilo_we[1]) hi_q <= bus.hilo_wdata;
                if (bus.hilo_we[0]) lo_q <= bus.hilo_wdata;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq: latency, signed/unsigned results, divide-by-zero,
// flush, back-to-back, async reset and (with MDU_HILO_WRITE_EN) direct HI writes.
module tb_mdu_seq;
    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mdu_seq_if #(.N(N)) bus ();

    mdu_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Called at the negedge of cycle 0 (start already driven); returns at the negedge of cycle N+3
    task automatic run_to_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input logic exp_dbz, input bit stray = 1'b0, input bit chain = 1'b0,
                               input logic [1:0] cop = 2'b00, input logic [31:0] ca = 0,
                               input logic [31:0] cb = 0);
        bit win_ok = 1'b1;
        for (int c = 1; c <= int'(N) + 2; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) win_ok = 1'b0;
            if (stray && c == 5) issue(2'b00, 32'd9, 32'd9);
            else bus.start = 1'b0;
        end
        check({tag, ":busy_window"}, 32'(win_ok), 32'd1);
        @(negedge clk);
        check({tag, ":done"}, 32'(bus.done), 32'd1);
        check({tag, ":busy"}, 32'(bus.busy), 32'd0);
        check({tag, ":hi"}, bus.hi, exp_hi);
        check({tag, ":lo"}, bus.lo, exp_lo);
        check({tag, ":dbz"}, 32'(bus.dbz), 32'(exp_dbz));
        if (chain) issue(cop, ca, cb);
        else bus.start = 1'b0;
    endtask

    initial begin
        bit quiet;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
`ifdef MDU_HILO_WRITE_EN
        bus.hilo_we    = 2'b00;
        bus.hilo_wdata = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst:busy", 32'(bus.busy), 32'd0);
        check("rst:done", 32'(bus.done), 32'd0);
        check("rst:hi", bus.hi, 32'd0);
        check("rst:lo", bus.lo, 32'd0);
        check("rst:dbz", 32'(bus.dbz), 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_to_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        run_to_done("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

        @(negedge clk);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        run_to_done("div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        @(negedge clk);
        issue(2'b10, 32'd5, 32'd0);
        run_to_done("divu_5d0", 32'd5, 32'hFFFF_FFFF, 1'b1);

        @(negedge clk);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_to_done("div_ovf", 32'd0, 32'h8000_0000, 1'b0);

        // Flush in cycle 10: unit idles, HI/LO/dbz keep the div_ovf results
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd4);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush:busy_c11", 32'(bus.busy), 32'd0);
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
        end
        check("flush:quiet", 32'(quiet), 32'd1);
        check("flush:hi", bus.hi, 32'd0);
        check("flush:lo", bus.lo, 32'h8000_0000);
        check("flush:dbz", 32'(bus.dbz), 32'd0);
        issue(2'b00, 32'd3, 32'd4);
        run_to_done("multu_3x4", 32'd0, 32'd12, 1'b0);

        // Back-to-back with a stray start while busy
        @(negedge clk);
        issue(2'b10, 32'd100, 32'd7);
        run_to_done("divu_100d7", 32'd2, 32'd14, 1'b0, 1'b1, 1'b1, 2'b00, 32'd2, 32'd3);
        run_to_done("multu_2x3", 32'd0, 32'd6, 1'b0, 1'b1);

        // Async reset in cycle 20 of a MULT
        @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst:busy", 32'(bus.busy), 32'd0);
        check("midrst:done", 32'(bus.done), 32'd0);
        check("midrst:hi", bus.hi, 32'd0);
        check("midrst:lo", bus.lo, 32'd0);
        check("midrst:dbz", 32'(bus.dbz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        run_to_done("mult_after_rst", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

`ifdef MDU_HILO_WRITE_EN
        @(negedge clk);
        bus.hilo_we    = 2'b10;
        bus.hilo_wdata = 32'h0000_1234;
        @(negedge clk);
        bus.hilo_we = 2'b00;
        check("mthi:hi", bus.hi, 32'h0000_1234);
        check("mthi:lo", bus.lo, 32'hFFFF_FFEB);
        check("mthi:dbz", 32'(bus.dbz), 32'd0);
        check("mthi:done", 32'(bus.done), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
